uart_cmd_parser: RTL and testbench
==================================

Name: uart_cmd_parser

Overview:
- Receive-side counterpart of the IAGC UART logger: consumes bytes from the UART receiver and decodes fixed 5-byte command frames sent by the host.
- Updates IAGC control registers (reference amplitude, enable) and returns a 1-byte ACK/NAK to the UART transmitter over a valid/ready handshake.
- Sits between the UART RX core and the IAGC control path; the ACK output is muxed onto the TX path.

Parameters:
AMPLITUDE_DATA_SIZE, 16, width of reference amplitude register (fixed at 2 bytes)
UART_DATA_SIZE, 8, UART byte width
HEADER_BYTE, 8'hA5, frame start marker
REF_DEFAULT, 16'h4000, reset value of reference amplitude
TIMEOUT_TICKS, 1000000, max clocks between bytes inside a frame before abort

Ports:
i_clock  input  1  system clock, all logic on rising edge
i_resetN  input  1  asynchronous active-low reset
i_rxData  input  UART_DATA_SIZE  received byte, valid when i_rxValid high
i_rxValid  input  1  one-cycle strobe per received byte
i_ackReady  input  1  UART TX can accept a byte
o_ackData  output  UART_DATA_SIZE  ACK/NAK byte to transmit
o_ackValid  output  1  ACK byte pending; held until accepted
o_referenceAmplitude  output  AMPLITUDE_DATA_SIZE  commanded reference amplitude
o_refUpdate  output  1  one-cycle pulse when reference amplitude written
o_iagcEnable  output  1  commanded IAGC enable
o_errorCount  output  8  saturating count of bad frames

Behaviour:
- Reset (async, i_resetN low): state IDLE; o_referenceAmplitude=REF_DEFAULT, o_iagcEnable=0, o_refUpdate=0, o_errorCount=0, o_ackValid=0, o_ackData=0, timeout counter=0, captured bytes=0. Reset mid-frame or mid-ACK discards everything.
- Frame: HEADER, CMD, DLO, DHI, CHK; data=16'{DHI,DLO}; CHK must equal CMD^DLO^DHI.
- Commands: 0x01 write o_referenceAmplitude=data and pulse o_refUpdate; 0x02 o_iagcEnable=DLO[0]; 0x03 o_errorCount=0. Any other CMD = error.
- States: IDLE, CMD, DLO, DHI, CHK, EXEC, ACK.
- IDLE: on i_rxValid with byte==HEADER_BYTE -> CMD; other bytes dropped silently (no error).
- CMD/DLO/DHI/CHK: each i_rxValid captures byte, advances; HEADER_BYTE value mid-frame is plain data (no resync). CHK -> EXEC.
- Timeout: counter clears on entry to CMD and on every i_rxValid; increments each cycle in CMD..CHK; when counter reaches TIMEOUT_TICKS with no byte -> IDLE, o_errorCount+1, no ACK.
- EXEC (one cycle): if checksum ok and CMD known -> perform command, o_ackData=CMD; else no register change, o_errorCount+1, o_ackData=8'hFF. Set o_ackValid=1; -> ACK.
- Latency: checksum byte sampled at edge E -> registers, o_refUpdate, o_ackValid all change at edge E+1; o_refUpdate high exactly one cycle.
- ACK: o_ackValid and o_ackData stable until cycle where o_ackValid & i_ackReady; at that edge o_ackValid=0, -> IDLE. Bytes arriving in EXEC/ACK are dropped and not counted.
- o_errorCount saturates at 255; clear command on a saturated counter gives 0. Clear has priority: frame 0x03 itself never counts as error.
- Unknown-state encoding -> IDLE.

Test Plan:
- After reset release: o_referenceAmplitude=16'h4000, o_iagcEnable=0, o_ackValid=0, o_errorCount=0.
- Bytes A5 01 34 12 27, i_ackReady=1 -> one edge after CHK: o_referenceAmplitude=16'h1234, o_refUpdate 1-cycle pulse, o_ackData=01 with o_ackValid for one cycle.
- Bytes A5 02 01 00 03 with i_ackReady=0 for 20 cycles -> o_iagcEnable=1; o_ackValid=1, o_ackData=02 held 20 cycles, dropped the cycle after i_ackReady rises.
- Bad checksum A5 01 34 12 00 -> amplitude unchanged, o_ackData=FF, o_errorCount=1; unknown CMD A5 07 00 00 07 -> FF, o_errorCount=2.
- TIMEOUT_TICKS=100: send A5 01 then idle 100 cycles -> return to IDLE, o_errorCount+1, no o_ackValid; next full valid frame accepted normally.
- Leading junk 00 FF then valid frame -> junk ignored, no error; assert i_resetN low between DLO and DHI -> all outputs to reset values, following frame parses from IDLE.

Source files
------------

// File: rtl/uart_cmd_parser_if.sv
// UART-side handshake bundle for the command parser: RX byte strobe in,
// ACK/NAK byte out over valid/ready.
interface uart_cmd_parser_if #(
  parameter int UART_DATA_SIZE = 8
);
  logic [UART_DATA_SIZE-1:0] i_rxData;
  logic                      i_rxValid;
  logic                      i_ackReady;
  logic [UART_DATA_SIZE-1:0] o_ackData;
  logic                      o_ackValid;

  // UART cores side: supplies RX bytes and TX readiness
  modport master (
    output i_rxData, i_rxValid, i_ackReady,
    input  o_ackData, o_ackValid
  );

  // Parser side
  modport slave (
    input  i_rxData, i_rxValid, i_ackReady,
    output o_ackData, o_ackValid
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// Decodes 5-byte host command frames (HEADER, CMD, DLO, DHI, CHK) into IAGC
// control registers and answers each complete frame with an ACK/NAK byte.
module uart_cmd_parser #(
  parameter int                        AMPLITUDE_DATA_SIZE = 16,
  parameter int                        UART_DATA_SIZE      = 8,
  parameter logic [UART_DATA_SIZE-1:0] HEADER_BYTE         = 8'hA5,
  parameter logic [AMPLITUDE_DATA_SIZE-1:0] REF_DEFAULT    = 16'h4000,
  parameter int                        TIMEOUT_TICKS       = 1000000
) (
  input  logic                           i_clock,
  input  logic                           i_resetN,
  uart_cmd_parser_if.slave               uart,
  output logic [AMPLITUDE_DATA_SIZE-1:0] o_referenceAmplitude,
  output logic                           o_refUpdate,
  output logic                           o_iagcEnable,
  output logic [7:0]                     o_errorCount
);

  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CMD  = 3'd1,
    S_DLO  = 3'd2,
    S_DHI  = 3'd3,
    S_CHK  = 3'd4,
    S_EXEC = 3'd5,
    S_ACK  = 3'd6
  } state_t;

  state_t                    state;
  logic [TW-1:0]             tmo_cnt;
  logic [UART_DATA_SIZE-1:0] cmd_byte;
  logic [UART_DATA_SIZE-1:0] dlo_byte;
  logic [UART_DATA_SIZE-1:0] dhi_byte;
  logic [UART_DATA_SIZE-1:0] chk_byte;
  logic                      chk_ok;
  logic                      in_frame;

  assign chk_ok   = (chk_byte == (cmd_byte ^ dlo_byte ^ dhi_byte));
  assign in_frame = (state == S_CMD) || (state == S_DLO) ||
                    (state == S_DHI) || (state == S_CHK);

  // Frame FSM with registered control outputs, timeout and error counter
  always_ff @(posedge i_clock or negedge i_resetN) begin
    if (!i_resetN) begin
      state                <= S_IDLE;
      tmo_cnt              <= '0;
      cmd_byte             <= '0;
      dlo_byte             <= '0;
      dhi_byte             <= '0;
      chk_byte             <= '0;
      o_referenceAmplitude <= REF_DEFAULT;
      o_refUpdate          <= 1'b0;
      o_iagcEnable         <= 1'b0;
      o_errorCount         <= '0;
      uart.o_ackData       <= '0;
      uart.o_ackValid      <= 1'b0;
    end else begin
      o_refUpdate <= 1'b0;
      // Abort on inter-byte silence; a byte arriving the same cycle wins
      if (in_frame && !uart.i_rxValid && tmo_cnt == TMO_LAST) begin
        state   <= S_IDLE;
        tmo_cnt <= '0;
        if (o_errorCount != 8'hFF) o_errorCount <= o_errorCount + 8'd1;
      end else begin
        if (in_frame) tmo_cnt <= uart.i_rxValid ? '0 : tmo_cnt + 1'b1;
        case (state)
          S_IDLE: begin
            tmo_cnt <= '0;
            if (uart.i_rxValid && uart.i_rxData == HEADER_BYTE) state <= S_CMD;
          end
          S_CMD: if (uart.i_rxValid) begin
            cmd_byte <= uart.i_rxData;
            state    <= S_DLO;
          end
          S_DLO: if (uart.i_rxValid) begin
            dlo_byte <= uart.i_rxData;
            state    <= S_DHI;
          end
          S_DHI: if (uart.i_rxValid) begin
            dhi_byte <= uart.i_rxData;
            state    <= S_CHK;
          end
          S_CHK: if (uart.i_rxValid) begin
            chk_byte <= uart.i_rxData;
            state    <= S_EXEC;
          end
          S_EXEC: begin
            uart.o_ackValid <= 1'b1;
            state           <= S_ACK;
            uart.o_ackData  <= cmd_byte;
            if (chk_ok && cmd_byte == 8'h01) begin
              o_referenceAmplitude <= {dhi_byte, dlo_byte};
              o_refUpdate          <= 1'b1;
            end else if (chk_ok && cmd_byte == 8'h02) begin
              o_iagcEnable <= dlo_byte[0];
            end else if (chk_ok && cmd_byte == 8'h03) begin
              o_errorCount <= '0;
            end else begin
              uart.o_ackData <= 8'hFF;
              if (o_errorCount != 8'hFF) o_errorCount <= o_errorCount + 8'd1;
            end
          end
          S_ACK: if (uart.i_ackReady) begin
            uart.o_ackValid <= 1'b0;
            state           <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed self-checking bench for uart_cmd_parser (timeout shortened to 100).
module tb_uart_cmd_parser;
  logic        i_clock = 1'b0;
  logic        i_resetN = 1'b0;
  logic [15:0] ref_amp;
  logic        ref_upd;
  logic        iagc_en;
  logic [7:0]  err_cnt;
  int          checks = 0;
  int          errors = 0;

  uart_cmd_parser_if #(.UART_DATA_SIZE(8)) bus ();

  uart_cmd_parser #(
    .AMPLITUDE_DATA_SIZE(16),
    .UART_DATA_SIZE(8),
    .HEADER_BYTE(8'hA5),
    .REF_DEFAULT(16'h4000),
    .TIMEOUT_TICKS(100)
  ) dut (
    .i_clock(i_clock),
    .i_resetN(i_resetN),
    .uart(bus),
    .o_referenceAmplitude(ref_amp),
    .o_refUpdate(ref_upd),
    .o_iagcEnable(iagc_en),
    .o_errorCount(err_cnt)
  );

  always #5 i_clock = ~i_clock;

  // All drive/sample points are 1ns after a rising edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clock);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.i_rxData  = b;
    bus.i_rxValid = 1'b1;
    tick(1);
    bus.i_rxValid = 1'b0;
  endtask

  // Leaves time 1ns after the edge that sampled the checksum byte.
  task automatic send_frame(input logic [7:0] c, input logic [7:0] lo,
                            input logic [7:0] hi, input logic [7:0] ck);
    send_byte(8'hA5);
    send_byte(c);
    send_byte(lo);
    send_byte(hi);
    send_byte(ck);
  endtask

  task automatic test_reset;
    bus.i_rxData = '0; bus.i_rxValid = 1'b0; bus.i_ackReady = 1'b1;
    i_resetN = 1'b0;
    tick(3);
    i_resetN = 1'b1;
    tick(1);
    checks++; if (ref_amp !== 16'h4000) begin errors++; $display("FAIL reset_ref got %h want 4000", ref_amp); end
    checks++; if (iagc_en !== 1'b0) begin errors++; $display("FAIL reset_en got %b want 0", iagc_en); end
    checks++; if (bus.o_ackValid !== 1'b0) begin errors++; $display("FAIL reset_ackv got %b want 0", bus.o_ackValid); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err got %0d want 0", err_cnt); end
  endtask

  task automatic test_write_ref;
    bus.i_ackReady = 1'b1;
    send_frame(8'h01, 8'h34, 8'h12, 8'h27);
    checks++; if (bus.o_ackValid !== 1'b0 || ref_upd !== 1'b0) begin errors++; $display("FAIL wr_early ackv %b upd %b want 0 0", bus.o_ackValid, ref_upd); end
    tick(1);
    checks++; if (ref_amp !== 16'h1234) begin errors++; $display("FAIL wr_ref got %h want 1234", ref_amp); end
    checks++; if (ref_upd !== 1'b1) begin errors++; $display("FAIL wr_upd got %b want 1", ref_upd); end
    checks++; if (bus.o_ackValid !== 1'b1 || bus.o_ackData !== 8'h01) begin errors++; $display("FAIL wr_ack v %b d %h want 1 01", bus.o_ackValid, bus.o_ackData); end
    tick(1);
    checks++; if (ref_upd !== 1'b0 || bus.o_ackValid !== 1'b0) begin errors++; $display("FAIL wr_pulse upd %b ackv %b want 0 0", ref_upd, bus.o_ackValid); end
  endtask

  task automatic test_ack_hold;
    int bad = 0;
    bus.i_ackReady = 1'b0;
    send_frame(8'h02, 8'h01, 8'h00, 8'h03);
    tick(1);
    checks++; if (iagc_en !== 1'b1) begin errors++; $display("FAIL en_set got %b want 1", iagc_en); end
    for (int i = 0; i < 20; i++) begin
      if (bus.o_ackValid !== 1'b1 || bus.o_ackData !== 8'h02) bad++;
      // A frame arriving while the ACK is pending must be dropped
      if (i == 2) begin send_frame(8'h01, 8'h00, 8'h00, 8'h01); i += 4; end
      else tick(1);
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL ack_hold bad_cycles %0d want 0", bad); end
    bus.i_ackReady = 1'b1;
    tick(1);
    checks++; if (bus.o_ackValid !== 1'b0) begin errors++; $display("FAIL ack_drop got %b want 0", bus.o_ackValid); end
    checks++; if (ref_amp !== 16'h1234 || err_cnt !== 8'd0) begin errors++; $display("FAIL ack_ignore ref %h err %0d want 1234 0", ref_amp, err_cnt); end
  endtask

  task automatic test_errors;
    send_frame(8'h01, 8'h34, 8'h12, 8'h00);
    tick(1);
    checks++; if (ref_amp !== 16'h1234 || ref_upd !== 1'b0) begin errors++; $display("FAIL badchk_ref %h upd %b want 1234 0", ref_amp, ref_upd); end
    checks++; if (bus.o_ackData !== 8'hFF || err_cnt !== 8'd1) begin errors++; $display("FAIL badchk_nak d %h err %0d want FF 1", bus.o_ackData, err_cnt); end
    tick(1);
    send_frame(8'h07, 8'h00, 8'h00, 8'h07);
    tick(1);
    checks++; if (bus.o_ackData !== 8'hFF || err_cnt !== 8'd2) begin errors++; $display("FAIL badcmd_nak d %h err %0d want FF 2", bus.o_ackData, err_cnt); end
    tick(1);
  endtask

  task automatic test_timeout;
    int ackseen = 0;
    send_byte(8'hA5);
    send_byte(8'h01);
    for (int i = 0; i < 90; i++) begin
      if (bus.o_ackValid) ackseen++;
      tick(1);
    end
    checks++; if (err_cnt !== 8'd2) begin errors++; $display("FAIL tmo_early err %0d want 2", err_cnt); end
    for (int i = 0; i < 20; i++) begin
      if (bus.o_ackValid) ackseen++;
      tick(1);
    end
    checks++; if (err_cnt !== 8'd3) begin errors++; $display("FAIL tmo_err err %0d want 3", err_cnt); end
    checks++; if (ackseen != 0) begin errors++; $display("FAIL tmo_noack cycles %0d want 0", ackseen); end
    send_frame(8'h03, 8'h00, 8'h00, 8'h03);
    tick(1);
    checks++; if (bus.o_ackData !== 8'h03 || err_cnt !== 8'd0) begin errors++; $display("FAIL tmo_next d %h err %0d want 03 0", bus.o_ackData, err_cnt); end
    tick(1);
  endtask

  task automatic test_junk_and_reset;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_frame(8'h01, 8'hCD, 8'hAB, 8'h67);
    tick(1);
    checks++; if (ref_amp !== 16'hABCD || err_cnt !== 8'd0) begin errors++; $display("FAIL junk ref %h err %0d want ABCD 0", ref_amp, err_cnt); end
    tick(1);
    send_frame(8'h09, 8'h00, 8'h00, 8'h00);
    tick(2);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h11);
    i_resetN = 1'b0;
    #2;
    checks++; if (ref_amp !== 16'h4000 || iagc_en !== 1'b0 || err_cnt !== 8'd0 || bus.o_ackValid !== 1'b0)
      begin errors++; $display("FAIL midrst ref %h en %b err %0d ackv %b want 4000 0 0 0", ref_amp, iagc_en, err_cnt, bus.o_ackValid); end
    tick(2);
    i_resetN = 1'b1;
    tick(1);
    send_byte(8'h22);
    send_frame(8'h02, 8'h01, 8'h00, 8'h03);
    tick(1);
    checks++; if (iagc_en !== 1'b1 || bus.o_ackData !== 8'h02 || err_cnt !== 8'd0)
      begin errors++; $display("FAIL postrst en %b d %h err %0d want 1 02 0", iagc_en, bus.o_ackData, err_cnt); end
    tick(1);
  endtask

  task automatic test_saturate;
    for (int i = 0; i < 260; i++) begin
      send_frame(8'h07, 8'h00, 8'h00, 8'h07);
      tick(2);
    end
    checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL sat err %0d want 255", err_cnt); end
    send_frame(8'h03, 8'h00, 8'h00, 8'h03);
    tick(1);
    checks++; if (err_cnt !== 8'd0 || bus.o_ackData !== 8'h03) begin errors++; $display("FAIL sat_clr err %0d d %h want 0 03", err_cnt, bus.o_ackData); end
    tick(1);
  endtask

  initial begin
    test_reset();
    test_write_ref();
    test_ack_hold();
    test_errors();
    test_timeout();
    test_junk_and_reset();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
